mbist_march_ctrl: RTL and testbench

//   March C- MBIST sequencer for one sram_wrapper instance. Drives the wrapper's cs/we/re/addr/wdata
//   and checks rdata against expected background. Reports pass/fail, first-fail info and a fail count.

---
 rtl/mbist_march_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mbist_march_ctrl.sv
// March C- MBIST sequencer: one memory op per cycle, reads checked READ_LATENCY cycles after issue.
// Latency: done at start+10N+READ_LATENCY+1; no backpressure, start is ignored while a run is active.
module mbist_march_ctrl #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           fail_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [DATA_WIDTH-1:0] fail_rdata,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
    localparam int DCW = $clog2(READ_LATENCY + 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;
    logic   accept;

    logic [2:0]            elem;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  phase;
    logic [DCW-1:0]        drain_cnt;

    logic op_rd;
    logic op_bg;
    logic two_op;
    logic down;
    logic elem_end;
    logic op_last;

    logic [2:0] iss_elem;
    logic       iss_bg;

    logic [READ_LATENCY-1:0]                 pipe_vld;
    logic [READ_LATENCY-1:0]                 pipe_bg;
    logic [READ_LATENCY-1:0][ADDR_WIDTH-1:0] pipe_addr;
    logic [READ_LATENCY-1:0][2:0]            pipe_elem;

    logic [DATA_WIDTH-1:0] exp_word;
    logic                  mismatch;
    logic                  first_fail;
    logic [15:0]           fail_count_nxt;

    // Decode the op pointed to by (elem, phase): two-op elements read the old background first.
    always_comb begin
        op_rd  = 1'b0;
        op_bg  = 1'b0;
        two_op = 1'b0;
        down   = 1'b0;
        unique case (elem)
            3'd0: begin
                op_rd = 1'b0;
                op_bg = 1'b0;
            end
            3'd1: begin
                op_rd  = ~phase;
                op_bg  = phase;
                two_op = 1'b1;
            end
            3'd2: begin
                op_rd  = ~phase;
                op_bg  = ~phase;
                two_op = 1'b1;
            end
            3'd3: begin
                op_rd  = ~phase;
                op_bg  = phase;
                two_op = 1'b1;
                down   = 1'b1;
            end
            3'd4: begin
                op_rd  = ~phase;
                op_bg  = ~phase;
                two_op = 1'b1;
                down   = 1'b1;
            end
            default: begin
                op_rd = 1'b1;
                op_bg = 1'b0;
            end
        endcase
    end

    assign elem_end = down ? (addr == '0) : (addr == ADDR_MAX);
    assign op_last  = (elem == 3'd5) && (addr == ADDR_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (op_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_cnt == DCW'(READ_LATENCY)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sequence counters: second op at an address before advancing; reload N-1 entering down elements.
    always_ff @(posedge clk) begin
        if (reset || accept) begin
            elem  <= 3'd0;
            addr  <= '0;
            phase <= 1'b0;
        end else if (state == RUN) begin
            if (two_op && !phase) begin
                phase <= 1'b1;
            end else begin
                phase <= 1'b0;
                if (elem_end) begin
                    elem <= elem + 3'd1;
                    addr <= (elem == 3'd2 || elem == 3'd3) ? ADDR_MAX : '0;
                end else if (down) begin
                    addr <= addr - ADDR_WIDTH'(1);
                end else begin
                    addr <= addr + ADDR_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || state != DRAIN) begin
            drain_cnt <= '0;
        end else begin
            drain_cnt <= drain_cnt + DCW'(1);
        end
    end

    // Registered memory interface; address and write data hold outside RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            iss_elem  <= 3'd0;
            iss_bg    <= 1'b0;
        end else if (state == RUN) begin
            mem_cs    <= 1'b1;
            mem_we    <= ~op_rd;
            mem_re    <= op_rd;
            mem_addr  <= addr;
            mem_wdata <= op_rd ? '0 : {DATA_WIDTH{op_bg}};
            iss_elem  <= elem;
            iss_bg    <= op_bg;
        end else begin
            mem_cs <= 1'b0;
            mem_we <= 1'b0;
            mem_re <= 1'b0;
        end
    end

    // Delay line fed from the issued op so its tail lines up with mem_rdata.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_vld  <= '0;
            pipe_bg   <= '0;
            pipe_addr <= '0;
            pipe_elem <= '0;
        end else begin
            pipe_vld[0]  <= mem_re;
            pipe_bg[0]   <= iss_bg;
            pipe_addr[0] <= mem_addr;
            pipe_elem[0] <= iss_elem;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_bg[i]   <= pipe_bg[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
                pipe_elem[i] <= pipe_elem[i-1];
            end
        end
    end

    always_comb begin
        exp_word       = {DATA_WIDTH{pipe_bg[READ_LATENCY-1]}};
        mismatch       = pipe_vld[READ_LATENCY-1] && (mem_rdata != exp_word);
        first_fail     = mismatch && (fail_count == 16'd0);
        fail_count_nxt = fail_count;
        if (mismatch && fail_count != 16'hFFFF) begin
            fail_count_nxt = fail_count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || accept) begin
            fail_count <= 16'd0;
            fail_addr  <= '0;
            fail_elem  <= 3'd0;
            fail_rdata <= '0;
            pass       <= 1'b0;
        end else begin
            fail_count <= fail_count_nxt;
            if (first_fail) begin
                fail_addr  <= pipe_addr[READ_LATENCY-1];
                fail_elem  <= pipe_elem[READ_LATENCY-1];
                fail_rdata <= mem_rdata;
            end
            // The last compare lands on the same edge that enters DONE.
            if (state == DRAIN && state_nxt == DONE) begin
                pass <= (fail_count_nxt == 16'd0);
            end
        end
    end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: two instances (READ_LATENCY 1 and 2) on behavioural memories with
// injectable stuck-at faults, checked against a march-table reference model.
module tb_mbist_march_ctrl;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int N  = 1 << AW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          start_i [2];
    logic          busy_o  [2];
    logic          done_o  [2];
    logic          pass_o  [2];
    logic [15:0]   fcnt    [2];
    logic [AW-1:0] faddr   [2];
    logic [2:0]    felem   [2];
    logic [DW-1:0] frdata  [2];
    logic          cs      [2];
    logic          we      [2];
    logic          re      [2];
    logic [AW-1:0] maddr   [2];
    logic [DW-1:0] wdat    [2];
    logic [DW-1:0] rdat    [2];

    logic [AW-1:0] flt_addr;
    logic [DW-1:0] sa0_m;
    logic [DW-1:0] sa1_m;

    mbist_march_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1)) u_dut_rl1 (
        .clk(clk), .reset(reset), .start(start_i[0]),
        .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]), .fail_count(fcnt[0]),
        .fail_addr(faddr[0]), .fail_elem(felem[0]), .fail_rdata(frdata[0]),
        .mem_cs(cs[0]), .mem_we(we[0]), .mem_re(re[0]), .mem_addr(maddr[0]),
        .mem_wdata(wdat[0]), .mem_rdata(rdat[0])
    );

    mbist_march_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2)) u_dut_rl2 (
        .clk(clk), .reset(reset), .start(start_i[1]),
        .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]), .fail_count(fcnt[1]),
        .fail_addr(faddr[1]), .fail_elem(felem[1]), .fail_rdata(frdata[1]),
        .mem_cs(cs[1]), .mem_we(we[1]), .mem_re(re[1]), .mem_addr(maddr[1]),
        .mem_wdata(wdat[1]), .mem_rdata(rdat[1])
    );

    // Memory under test: registered read, latency g+1, stuck-at faults applied on read.
    for (genvar g = 0; g < 2; g++) begin : g_mem
        logic [DW-1:0] mem [N];
        logic [DW-1:0] rq  [2];
        always @(posedge clk) begin
            if (cs[g] && we[g]) mem[maddr[g]] <= wdat[g];
            if (cs[g] && re[g])
                rq[0] <= (maddr[g] == flt_addr) ? ((mem[maddr[g]] & ~sa0_m) | sa1_m) : mem[maddr[g]];
            rq[1] <= rq[0];
        end
        assign rdat[g] = rq[g];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit rd;
        int addr;
        bit bg;
        int elem;
    } op_t;
    op_t ops[$];

    // March C- as a table: op count, direction, and per-slot read flag / background.
    function automatic void build_ops();
        int nop   [6] = '{1, 2, 2, 2, 2, 1};
        bit dn    [6] = '{0, 0, 0, 1, 1, 0};
        bit rd_t  [6][2] = '{'{0, 0}, '{1, 0}, '{1, 0}, '{1, 0}, '{1, 0}, '{1, 0}};
        bit bg_t  [6][2] = '{'{0, 0}, '{0, 1}, '{1, 0}, '{0, 1}, '{1, 0}, '{0, 0}};
        op_t o;
        ops.delete();
        for (int e = 0; e < 6; e++)
            for (int i = 0; i < N; i++)
                for (int s = 0; s < nop[e]; s++) begin
                    o.rd   = rd_t[e][s];
                    o.addr = dn[e] ? (N - 1 - i) : i;
                    o.bg   = bg_t[e][s];
                    o.elem = e;
                    ops.push_back(o);
                end
    endfunction

    int            exp_cnt;
    int            exp_faddr;
    int            exp_felem;
    logic [DW-1:0] exp_frd;

    function automatic void model();
        logic [DW-1:0] m [N];
        logic [DW-1:0] v;
        exp_cnt = 0; exp_faddr = 0; exp_felem = 0; exp_frd = '0;
        foreach (ops[j]) begin
            if (!ops[j].rd) begin
                m[ops[j].addr] = {DW{ops[j].bg}};
            end else begin
                v = m[ops[j].addr];
                if (ops[j].addr == int'(flt_addr)) v = (v & ~sa0_m) | sa1_m;
                if (v != {DW{ops[j].bg}}) begin
                    if (exp_cnt == 0) begin
                        exp_faddr = ops[j].addr;
                        exp_felem = ops[j].elem;
                        exp_frd   = v;
                    end
                    if (exp_cnt < 65535) exp_cnt++;
                end
            end
        end
    endfunction

    function automatic logic [AW+DW+2:0] issue_vec(input int s);
        return {cs[s], we[s], re[s], maddr[s], wdat[s]};
    endfunction

    function automatic logic [AW+DW+2:0] exp_issue(input int k);
        op_t o;
        if (k >= 1 && k <= ops.size()) begin
            o = ops[k-1];
            return {1'b1, !o.rd, o.rd, AW'(o.addr), o.rd ? DW'(0) : {DW{o.bg}}};
        end
        return {3'b000, AW'(N - 1), DW'(0)};
    endfunction

    function automatic logic [127:0] all_out(input int s);
        return {busy_o[s], done_o[s], pass_o[s], fcnt[s], faddr[s], felem[s], frdata[s],
                cs[s], we[s], re[s], maddr[s], wdat[s]};
    endfunction

    function automatic logic [127:0] result_vec(input int s);
        return {pass_o[s], fcnt[s], faddr[s], felem[s], frdata[s]};
    endfunction

    function automatic logic [127:0] exp_result();
        return {exp_cnt == 0, 16'(exp_cnt), AW'(exp_faddr), 3'(exp_felem), exp_frd};
    endfunction

    // One run on instance s; optional second start pulse and mid-run reset at given cycles.
    task automatic run(input int s, input int restart_at, input int abort_at);
        int rl;
        int done_at;
        int dn;
        rl      = s + 1;
        done_at = -1;
        model();
        @(negedge clk);
        start_i[s] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i[s] = 1'b0;
        check("accept", {busy_o[s], done_o[s], pass_o[s], fcnt[s]}, {3'b100, 16'd0});
        for (int k = 1; k <= 10 * N + rl + 10; k++) begin
            @(negedge clk);
            start_i[s] = (k == restart_at);
            if (k == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                check("abort_outputs", all_out(s), '0);
                reset = 1'b0;
                dn = 0;
                repeat (20) begin
                    @(negedge clk);
                    dn += int'(done_o[s]);
                end
                check("abort_no_done", dn, 0);
                return;
            end
            check("issue", issue_vec(s), exp_issue(k));
            check("protocol", !(we[s] && re[s]) && (cs[s] || !(we[s] || re[s])), 1);
            if (done_o[s]) begin
                done_at = k;
                break;
            end
        end
        check("done_cycle", done_at, 10 * N + rl + 1);
        check("busy_at_done", busy_o[s], 0);
        check("result", result_vec(s), exp_result());
        @(negedge clk);
        check("held_after_done", {done_o[s], busy_o[s], result_vec(s)}, {2'b00, exp_result()});
    endtask

    initial begin
        int s;
        int kind;
        int b1;
        build_ops();
        start_i[0] = 1'b0;
        start_i[1] = 1'b0;
        flt_addr = '0;
        sa0_m    = '0;
        sa1_m    = '0;
        reset    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rl1", all_out(0), '0);
        check("reset_rl2", all_out(1), '0);
        reset = 1'b0;

        run(0, -1, -1);
        check("clean_const", result_vec(0), {1'b1, 16'd0, 4'd0, 3'd0, 32'd0});

        flt_addr = 4'd5; sa0_m = 32'h1; sa1_m = '0;
        run(0, -1, -1);
        check("sa0_const", result_vec(0), {1'b0, 16'd2, 4'd5, 3'd2, 32'hFFFF_FFFE});

        flt_addr = 4'd0; sa0_m = '0; sa1_m = 32'h8000_0000;
        run(0, -1, -1);
        check("sa1_const", {fcnt[0], faddr[0], felem[0], pass_o[0]}, {16'd3, 4'd0, 3'd1, 1'b0});

        sa1_m = '0;
        run(1, -1, -1);
        run(0, 50, -1);
        run(0, -1, 80);
        run(0, -1, -1);

        for (int it = 0; it < 12; it++) begin
            s        = int'($urandom_range(0, 1));
            kind     = int'($urandom_range(0, 3));
            b1       = int'($urandom_range(0, DW - 1));
            flt_addr = AW'($urandom_range(0, N - 1));
            sa0_m    = (kind == 1 || kind == 3) ? (32'd1 << b1) : '0;
            sa1_m    = (kind == 2 || kind == 3) ? (32'd1 << ((b1 + 1 + int'($urandom_range(0, DW - 2))) % DW)) : '0;
            run(s, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
